stencil_window_gen: RTL and testbench
=====================================

# stencil_window_gen

Upstream feeder for the 3-tap FP32 dot-product stage. It takes a scalar stream of FP32 samples through a valid/ready handshake and builds sliding windows of ST consecutive samples within each row. Each window is presented with a registered copy of the stencil weight vector, so the dot stage receives matched `in_data`/`in_weight` lanes plus its strobe. Windows never span a row boundary.

## Interface
Parameters:
- `BW`, 32: sample width in bits (FP32 bit pattern; the block does no arithmetic on it).
- `ST`, 3: stencil taps per window.
- `ROW_LEN`, 16: samples per row. `ROW_LEN >= ST` is required; smaller values are illegal.

Ports:
- `clock`, in, 1: sole clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low. Low at a rising edge resets all state.
- `in_valid`, in, 1: upstream sample valid.
- `in_ready`, out, 1: block can accept a sample this cycle.
- `in_data`, in, BW: FP32 sample.
- `wt_load`, in, 1: load the weight register from `wt_data`.
- `wt_data`, in, BW*ST: new weight vector, lane k at bits [BW*k +: BW].
- `out_valid`, out, 1: window valid. Drives the dot stage's `io_in_ready`.
- `out_ready`, in, 1: downstream accepts the window. Tie to 1 when the consumer never stalls.
- `out_data`, out, BW*ST: window. Lane 0 is the newest sample, lane ST-1 the oldest.
- `out_weight`, out, BW*ST: weight snapshot paired with `out_data`.
- `row_done`, out, 1: one-cycle pulse after the last sample of a row is accepted.

## Operation
- Accept: a sample is taken when `in_valid && in_ready`. `in_ready = reset && (!out_valid || out_ready)`, so there is one output register with pass-through on pop.
- Shift register: holds ST-1 prior samples. Column counter `col` runs 0..ROW_LEN-1.
- States:
  - FILL: `col < ST-1`. An accepted sample shifts in; no window is produced.
  - STREAM: `col >= ST-1`. An accepted sample shifts in, and `{prior ST-1 samples, new sample}` is captured into `out_data`. `out_weight` takes the current weight register and `out_valid` is set.
- Transitions:
  - FILL→STREAM when the accepted sample makes `col == ST-1`.
  - Accepting the sample at `col == ROW_LEN-1` sets `col` to 0 and returns to FILL. That sample still produces its window. The shift register is logically cleared, so the next window needs ST fresh samples.
- Yield: ROW_LEN-ST+1 windows per row.
- Output pop: `out_valid && out_ready` with no new capture clears `out_valid` next cycle. Pop plus capture in the same cycle keeps `out_valid` = 1 with the new window.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_weight` and `out_valid` hold, and `in_ready` = 0.
- Weights:
  - `wt_load` writes the weight register at the edge, in any state.
  - A capture in the same cycle uses the old weights.
  - Held output windows never change weight.
- `row_done` is asserted the cycle after the row's last sample is accepted.
- Reset values:
  - `out_valid` = 0, `row_done` = 0, `out_data` = 0, `col` = 0, state FILL.
  - Weight register and `out_weight` = 0x3F800000 per lane (1.0 each).
  - `in_ready` = 0 while `reset` is low.
- Reset mid-row or mid-stall discards the partial window and any pending output.

## Timing
- Latency: the completing sample is accepted at edge N; the window is valid on `out_data` from edge N through at least N+1 (valid during cycle N+1).
- Throughput: one window per cycle in STREAM with `out_ready` = 1.
- A row boundary costs ST-1 accept cycles with no output.
- `in_ready` is combinational from `out_valid`, `out_ready` and `reset`. There are no other combinational input-to-output paths.

## Test plan
- **Basic row** (`ROW_LEN`=4, `out_ready`=1): feed 3F800000, 40000000, 40400000, 40800000 back-to-back.
  - Windows 96'h3F800000_40000000_40400000, then 96'h40000000_40400000_40800000, on consecutive cycles, each with `out_weight` 96'h3F800000_3F800000_3F800000.
  - `row_done` pulses once, aligned with the second window.
- **Row boundary**: continue with 40A00000, 40C00000, 40E00000.
  - No window after the first two samples.
  - The third yields 96'h40A00000_40C00000_40E00000; there is no cross-row window containing 40800000.
- **Backpressure**: hold `out_ready`=0 when the first window appears.
  - `in_ready`=0 and the window is stable for 5 cycles.
  - Raising `out_ready` pops it and accepts the next sample in the same cycle.
- **Weight load**: pulse `wt_load` with 96'h4000000040800000C0000000 in the same cycle as the completing sample.
  - That window carries the old weights (all 1.0); the next window carries the new vector.
- **Reset mid-row**: drive `reset` low after two samples.
  - Next cycle `out_valid`=0, `in_ready`=0, and weights are back to 1.0.
  - After release, three new samples are needed before the first window.
- **Random stress**: random `in_valid`/`out_ready` over 200 samples against a scoreboard model. Window count = rows×(ROW_LEN-ST+1), with no lost or duplicated windows.

Source files
------------

// File: rtl/stencil_window_gen.sv
// rtl/stencil_window_gen.sv - sliding FP32 stencil window builder with paired weight snapshot
//
// Purpose: turns a scalar sample stream into windows of ST consecutive samples
// within a row, each paired with a registered copy of the weight vector, for
// the downstream dot-product stage. Windows never straddle a row boundary.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-low
//   in_valid   - upstream sample valid
//   in_ready   - sample can be accepted this cycle
//   in_data    - sample (BW bits, not interpreted)
//   wt_load    - load weight register from wt_data
//   wt_data    - weight vector, lane k at [BW*k +: BW]
//   out_valid  - window valid
//   out_ready  - downstream accepts the window
//   out_data   - window, lane 0 newest sample, lane ST-1 oldest
//   out_weight - weight snapshot paired with out_data
//   row_done   - one-cycle pulse after the last sample of a row is accepted

module stencil_window_gen #(
  parameter int BW      = 32,
  parameter int ST      = 3,
  parameter int ROW_LEN = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  input  logic             wt_load,
  input  logic [BW*ST-1:0] wt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW*ST-1:0] out_data,
  output logic [BW*ST-1:0] out_weight,
  output logic             row_done
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [BW*ST-1:0] WT_RESET = {ST{BW'(32'h3F800000)}};

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  // Prior ST-1 samples, packed so that lane j holds the sample j+1 accepts ago.
  logic [BW*(ST-1)-1:0]  r_shift;
  logic [BW*ST-1:0]      r_weight;
  logic [BW*ST-1:0]      r_out_data;
  logic [BW*ST-1:0]      r_out_weight;
  logic                  r_out_valid;
  logic                  r_row_done;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_last;
  logic [CW-1:0]         w_col_inc;
  logic [BW*ST-1:0]      w_window;

  // Single output register: a pop frees the slot for a capture in the same cycle.
  assign in_ready = reset && (!r_out_valid || out_ready);

  always_comb begin
    w_accept  = in_valid && in_ready;
    w_capture = w_accept && (r_state == S_STREAM);
    w_last    = (r_col == CW'(ROW_LEN - 1));
    w_col_inc = r_col + CW'(1);
    // Newest sample lands in lane 0; older samples move up one lane.
    w_window  = {r_shift, in_data};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_FILL;
      r_col        <= '0;
      r_shift      <= '0;
      r_weight     <= WT_RESET;
      r_out_data   <= '0;
      r_out_weight <= WT_RESET;
      r_out_valid  <= 1'b0;
      r_row_done   <= 1'b0;
    end else begin
      r_row_done <= 1'b0;

      if (wt_load) begin
        r_weight <= wt_data;
      end

      if (w_accept) begin
        r_shift <= w_window[BW*(ST-1)-1:0];
        if (w_last) begin
          // Stale shift contents are left in place; the FILL phase overwrites
          // all ST-1 lanes before the next window can be captured.
          r_col      <= '0;
          r_state    <= S_FILL;
          r_row_done <= 1'b1;
        end else begin
          r_col <= w_col_inc;
          if (w_col_inc == CW'(ST - 1)) begin
            r_state <= S_STREAM;
          end
        end
      end

      if (w_capture) begin
        r_out_data   <= w_window;
        // Old register value: a same-cycle wt_load applies to later windows.
        r_out_weight <= r_weight;
        r_out_valid  <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_weight = r_out_weight;
  assign row_done   = r_row_done;

endmodule

// File: tb/tb_stencil_window_gen.sv
// tb/tb_stencil_window_gen.sv - self-checking bench for stencil_window_gen

module tb_stencil_window_gen;

  localparam int BW      = 32;
  localparam int ST      = 3;
  localparam int ROW_LEN = 4;
  localparam int WW      = BW * ST;
  localparam logic [WW-1:0] ONES  = 96'h3F800000_3F800000_3F800000;
  localparam logic [WW-1:0] NEWWT = 96'h40000000_40800000_C0000000;
  localparam int N_STRESS = 200;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          wt_load;
  logic [WW-1:0] wt_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [WW-1:0] out_weight;
  logic          row_done;

  int checks;
  int failures;

  stencil_window_gen #(
    .BW      (BW),
    .ST      (ST),
    .ROW_LEN (ROW_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wt_load    (wt_load),
    .wt_data    (wt_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_weight (out_weight),
    .row_done   (row_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          v;
    logic [BW-1:0] d;
    logic          ld;
    logic [WW-1:0] wt;
    logic          e_valid;
    logic [WW-1:0] e_data;
    logic [WW-1:0] e_wt;
    logic          e_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds reset low for two edges, releases it at a falling edge.
  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    wt_load   = 1'b0;
    wt_data   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one sample at the falling edge, let one rising edge pass, sample #1 later.
  task automatic push(input logic [BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  logic [BW-1:0]  samples [N_STRESS];
  logic [WW-1:0]  exp_q [$];
  int             idx;
  int             popped;
  int             cyc;
  logic           acc;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 32'h3F800000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[1]  = '{1'b1, 32'h40000000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[2]  = '{1'b1, 32'h40400000, 1'b0, '0,    1'b1, 96'h3F800000_40000000_40400000, ONES, 1'b0};
    vecs[3]  = '{1'b1, 32'h40800000, 1'b0, '0,    1'b1, 96'h40000000_40400000_40800000, ONES, 1'b1};
    vecs[4]  = '{1'b1, 32'h40A00000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[5]  = '{1'b1, 32'h40C00000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[6]  = '{1'b1, 32'h40E00000, 1'b0, '0,    1'b1, 96'h40A00000_40C00000_40E00000, ONES, 1'b0};
    vecs[7]  = '{1'b1, 32'h41000000, 1'b0, '0,    1'b1, 96'h40C00000_40E00000_41000000, ONES, 1'b1};
    vecs[8]  = '{1'b1, 32'h41100000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[9]  = '{1'b1, 32'h41200000, 1'b0, '0,    1'b0, '0, ONES, 1'b0};
    vecs[10] = '{1'b1, 32'h41300000, 1'b1, NEWWT, 1'b1, 96'h41100000_41200000_41300000, ONES, 1'b0};
    vecs[11] = '{1'b1, 32'h41400000, 1'b0, '0,    1'b1, 96'h41200000_41300000_41400000, NEWWT, 1'b1};
    vecs[12] = '{1'b0, 32'h0,        1'b0, '0,    1'b0, '0, ONES, 1'b0};

    // Reset state, sampled while reset is still low.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    out_ready = 1'b1;
    wt_load   = 1'b0;
    wt_data   = '0;
    @(posedge clock);
    #1;
    check("rst_out_valid", WW'(out_valid), WW'(0));
    check("rst_in_ready", WW'(in_ready), WW'(0));
    check("rst_row_done", WW'(row_done), WW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_weight", out_weight, ONES);
    do_reset();

    // Basic row, row boundary and same-cycle weight load.
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      wt_load  = vecs[i].ld;
      wt_data  = vecs[i].wt;
      #1;
      check($sformatf("vec%0d_in_ready", i), WW'(in_ready), WW'(1));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_out_valid", i), WW'(out_valid), WW'(vecs[i].e_valid));
      check($sformatf("vec%0d_row_done", i), WW'(row_done), WW'(vecs[i].e_rd));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
        check($sformatf("vec%0d_out_weight", i), out_weight, vecs[i].e_wt);
      end
      @(negedge clock);
    end
    wt_load = 1'b0;

    // Backpressure: first window held for 5 cycles, then popped with a same-cycle accept.
    do_reset();
    out_ready = 1'b0;
    push(32'h00000A01); @(negedge clock);
    push(32'h00000A02); @(negedge clock);
    push(32'h00000A03);
    check("bp_out_valid", WW'(out_valid), WW'(1));
    check("bp_in_ready", WW'(in_ready), WW'(0));
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 32'h00000A04;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("bp_hold%0d_valid", c), WW'(out_valid), WW'(1));
      check($sformatf("bp_hold%0d_in_ready", c), WW'(in_ready), WW'(0));
      check($sformatf("bp_hold%0d_data", c), out_data, 96'h00000A01_00000A02_00000A03);
      check($sformatf("bp_hold%0d_weight", c), out_weight, ONES);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", WW'(in_ready), WW'(1));
    @(posedge clock);
    #1;
    check("bp_next_valid", WW'(out_valid), WW'(1));
    check("bp_next_data", out_data, 96'h00000A02_00000A03_00000A04);
    check("bp_row_done", WW'(row_done), WW'(1));
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("bp_drain_valid", WW'(out_valid), WW'(0));

    // Reset mid-row after a weight load: window state and weights return to defaults.
    @(negedge clock);
    wt_load = 1'b1;
    wt_data = NEWWT;
    @(posedge clock);
    @(negedge clock);
    wt_load = 1'b0;
    push(32'h00000B01); @(negedge clock);
    push(32'h00000B02); @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_in_ready_comb", WW'(in_ready), WW'(0));
    @(posedge clock);
    #1;
    check("mid_rst_out_valid", WW'(out_valid), WW'(0));
    check("mid_rst_in_ready", WW'(in_ready), WW'(0));
    check("mid_rst_out_weight", out_weight, ONES);
    @(negedge clock);
    reset = 1'b1;
    push(32'h00000C01);
    check("post_rst_s1_valid", WW'(out_valid), WW'(0));
    @(negedge clock);
    push(32'h00000C02);
    check("post_rst_s2_valid", WW'(out_valid), WW'(0));
    @(negedge clock);
    push(32'h00000C03);
    check("post_rst_s3_valid", WW'(out_valid), WW'(1));
    check("post_rst_s3_data", out_data, 96'h00000C01_00000C02_00000C03);
    check("post_rst_s3_weight", out_weight, ONES);
    @(negedge clock);

    // Random stress against a window model built from the sample list.
    do_reset();
    for (int i = 0; i < N_STRESS; i++) samples[i] = 32'h5000_0000 + 32'(i);
    for (int r = 0; r < N_STRESS / ROW_LEN; r++) begin
      for (int c = ST - 1; c < ROW_LEN; c++) begin
        exp_q.push_back({samples[r*ROW_LEN + c - 2], samples[r*ROW_LEN + c - 1], samples[r*ROW_LEN + c]});
      end
    end
    idx    = 0;
    popped = 0;
    cyc    = 0;
    while ((idx < N_STRESS || out_valid) && cyc < 5000) begin
      if (idx < N_STRESS) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = samples[idx];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (idx < N_STRESS) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stress_extra_window: got %h expected none", out_data);
        end else begin
          check($sformatf("stress_win%0d", popped), out_data, exp_q.pop_front());
          check($sformatf("stress_wt%0d", popped), out_weight, ONES);
        end
        popped++;
      end
      acc = in_valid && in_ready;
      @(posedge clock);
      if (acc) idx++;
      cyc++;
      @(negedge clock);
    end
    check("stress_timeout", WW'(cyc < 5000), WW'(1));
    check("stress_window_count", WW'(popped), WW'((N_STRESS / ROW_LEN) * (ROW_LEN - ST + 1)));
    check("stress_left_over", WW'(exp_q.size()), WW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
